// File: rtl/mem_wb_ctrl.sv
// MEM-stage sequencer: runs the data-memory handshake for loads/stores and
// drives the MEM/WB register feeding the writeback select mux.
//
// state | meaning
// IDLE  | accepting one instruction per cycle; ALU ops retire on the next edge
// BUSY  | memory access outstanding; upstream stalled until ready or timeout
module mem_wb_ctrl #(
   parameter int TIMEOUT     = 16,
   parameter int STALL_CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic                   in_MemRead,
   input  logic                   in_MemWrite,
   input  logic                   in_RegWrite,
   input  logic                   in_MemtoReg,
   input  logic [4:0]             in_WriteReg,
   input  logic [31:0]            in_ALUResult,
   input  logic [31:0]            in_WriteData,
   output logic                   stall,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [31:0]            mem_addr,
   output logic [31:0]            mem_wdata,
   input  logic                   mem_ready,
   input  logic [31:0]            mem_rdata,
   output logic                   wb_valid,
   output logic                   wb_RegWrite,
   output logic [4:0]             wb_WriteReg,
   output logic                   wb_MemtoReg,
   output logic [31:0]            wb_ALUResult,
   output logic [31:0]            wb_RD,
   output logic                   err_timeout,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam logic [7:0]             WAIT_LAST = 8'(TIMEOUT - 1);
   localparam logic [STALL_CNT_W-1:0] CNT_MAX   = '1;

   state_t      state;
   logic [7:0]  wait_cnt;
   logic        lat_we;
   logic        lat_RegWrite;
   logic        lat_MemtoReg;
   logic [4:0]  lat_WriteReg;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;

   // Memory side is driven straight from the latched instruction so it is
   // stable for all of BUSY and holds its last value afterwards.
   assign stall     = (state == BUSY);
   assign mem_req   = (state == BUSY);
   assign mem_we    = lat_we;
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;

   // FSM, instruction latch, MEM/WB register and status counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         lat_we       <= 1'b0;
         lat_RegWrite <= 1'b0;
         lat_MemtoReg <= 1'b0;
         lat_WriteReg <= '0;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         wb_valid     <= 1'b0;
         wb_RegWrite  <= 1'b0;
         wb_WriteReg  <= '0;
         wb_MemtoReg  <= 1'b0;
         wb_ALUResult <= '0;
         wb_RD        <= '0;
         err_timeout  <= 1'b0;
         stall_cnt    <= '0;
      end else begin
         wb_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (in_MemRead || in_MemWrite) begin
                     // read+write together is treated as a store
                     lat_we       <= in_MemWrite;
                     lat_RegWrite <= in_RegWrite;
                     lat_MemtoReg <= in_MemtoReg;
                     lat_WriteReg <= in_WriteReg;
                     lat_addr     <= in_ALUResult;
                     lat_wdata    <= in_WriteData;
                     wait_cnt     <= '0;
                     state        <= BUSY;
                  end else begin
                     wb_valid     <= 1'b1;
                     wb_RegWrite  <= in_RegWrite;
                     wb_WriteReg  <= in_WriteReg;
                     wb_MemtoReg  <= in_MemtoReg;
                     wb_ALUResult <= in_ALUResult;
                  end
               end
            end
            BUSY: begin
               if (stall_cnt != CNT_MAX) begin
                  stall_cnt <= stall_cnt + 1'b1;
               end
               if (mem_ready) begin
                  // ready wins even in the last allowed wait cycle
                  state        <= IDLE;
                  wb_valid     <= 1'b1;
                  wb_RegWrite  <= lat_RegWrite;
                  wb_WriteReg  <= lat_WriteReg;
                  wb_MemtoReg  <= lat_MemtoReg;
                  wb_ALUResult <= lat_addr;
                  if (!lat_we) begin
                     wb_RD <= mem_rdata;
                  end
               end else if (wait_cnt < WAIT_LAST) begin
                  wait_cnt <= wait_cnt + 8'd1;
               end else begin
                  // abort: retire without a register write, flag sticks
                  state        <= IDLE;
                  wb_valid     <= 1'b1;
                  wb_RegWrite  <= 1'b0;
                  wb_WriteReg  <= lat_WriteReg;
                  wb_MemtoReg  <= lat_MemtoReg;
                  wb_ALUResult <= lat_addr;
                  err_timeout  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_wb_ctrl.sv
// Directed bench for mem_wb_ctrl with a transaction-level reference model.
module tb_mem_wb_ctrl;

   localparam int TIMEOUT = 16;
   localparam int SCW     = 5;
   localparam int SMAX    = (1 << SCW) - 1;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           in_valid = 1'b0, in_MemRead = 1'b0, in_MemWrite = 1'b0;
   logic           in_RegWrite = 1'b0, in_MemtoReg = 1'b0;
   logic [4:0]     in_WriteReg = '0;
   logic [31:0]    in_ALUResult = '0, in_WriteData = '0;
   logic           stall, mem_req, mem_we;
   logic [31:0]    mem_addr, mem_wdata;
   logic           mem_ready = 1'b0;
   logic [31:0]    mem_rdata = '0;
   logic           wb_valid, wb_RegWrite, wb_MemtoReg;
   logic [4:0]     wb_WriteReg;
   logic [31:0]    wb_ALUResult, wb_RD;
   logic           err_timeout;
   logic [SCW-1:0] stall_cnt;

   mem_wb_ctrl #(.TIMEOUT(TIMEOUT), .STALL_CNT_W(SCW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
      .in_RegWrite(in_RegWrite), .in_MemtoReg(in_MemtoReg),
      .in_WriteReg(in_WriteReg), .in_ALUResult(in_ALUResult),
      .in_WriteData(in_WriteData),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite),
      .wb_WriteReg(wb_WriteReg), .wb_MemtoReg(wb_MemtoReg),
      .wb_ALUResult(wb_ALUResult), .wb_RD(wb_RD),
      .err_timeout(err_timeout), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: one pending memory transaction with an elapsed-cycle count.
   bit          started = 0;
   bit          m_busy = 0;
   int          m_elapsed = 0;
   bit          m_store, m_rw, m_m2r;
   logic [4:0]  m_wr;
   logic [31:0] m_addr = '0, m_wdata = '0;
   bit          e_wbv = 0, e_rw = 0, e_m2r = 0, e_err = 0;
   logic [4:0]  e_wr = '0;
   logic [31:0] e_alu = '0, e_rd = '0;
   int          e_scnt = 0;

   always @(posedge clk) begin
      if (reset) begin
         started = 1; m_busy = 0; m_elapsed = 0;
         m_addr = '0; m_wdata = '0; m_store = 0;
         e_wbv = 0; e_rw = 0; e_m2r = 0; e_err = 0;
         e_wr = '0; e_alu = '0; e_rd = '0; e_scnt = 0;
      end else if (started) begin
         e_wbv = 0;
         if (!m_busy) begin
            if (in_valid && (in_MemRead || in_MemWrite)) begin
               m_busy = 1; m_elapsed = 0;
               m_store = in_MemWrite; m_rw = in_RegWrite; m_m2r = in_MemtoReg;
               m_wr = in_WriteReg; m_addr = in_ALUResult; m_wdata = in_WriteData;
            end else if (in_valid) begin
               e_wbv = 1; e_rw = in_RegWrite; e_wr = in_WriteReg;
               e_m2r = in_MemtoReg; e_alu = in_ALUResult;
            end
         end else begin
            m_elapsed++;
            if (e_scnt < SMAX) e_scnt++;
            if (mem_ready || m_elapsed >= TIMEOUT) begin
               m_busy = 0; e_wbv = 1; e_wr = m_wr; e_m2r = m_m2r; e_alu = m_addr;
               if (mem_ready) begin
                  e_rw = m_rw;
                  if (!m_store) e_rd = mem_rdata;
               end else begin
                  e_rw = 0; e_err = 1;
               end
            end
         end
      end
   end

   // Compare the DUT with the model on every falling edge after the first reset.
   always @(negedge clk) begin
      if (started) begin
         chk("stall", stall, m_busy);
         chk("mem_req", mem_req, m_busy);
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_wdata", mem_wdata, m_wdata);
         if (m_busy) chk("mem_we", mem_we, m_store);
         chk("wb_valid", wb_valid, e_wbv);
         chk("wb_RegWrite", wb_RegWrite, e_rw);
         chk("wb_WriteReg", wb_WriteReg, e_wr);
         chk("wb_MemtoReg", wb_MemtoReg, e_m2r);
         chk("wb_ALUResult", wb_ALUResult, e_alu);
         chk("wb_RD", wb_RD, e_rd);
         chk("err_timeout", err_timeout, e_err);
         chk("stall_cnt", stall_cnt, e_scnt);
      end
   end

   int busy_seen = 0;
   always @(negedge clk) if (stall === 1'b1) busy_seen++;

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic alu_op(input logic [4:0] wr, input logic [31:0] alu);
      in_valid = 1; in_MemRead = 0; in_MemWrite = 0; in_RegWrite = 1; in_MemtoReg = 0;
      in_WriteReg = wr; in_ALUResult = alu;
      step();
      in_valid = 0;
      chk("alu wb_valid", wb_valid, 1'b1);
      chk("alu wb_ALUResult", wb_ALUResult, alu);
      chk("alu wb_WriteReg", wb_WriteReg, wr);
   endtask

   // ready_at = BUSY cycle carrying mem_ready, 0 = never (timeout)
   task automatic mem_op(input bit rd, input bit wr_en, input logic [4:0] wreg,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int ready_at, input logic [31:0] rdata);
      in_valid = 1; in_MemRead = rd; in_MemWrite = wr_en; in_RegWrite = rd && !wr_en;
      in_MemtoReg = rd && !wr_en; in_WriteReg = wreg; in_ALUResult = addr;
      in_WriteData = wdata;
      step();
      in_valid = 0;
      busy_seen = 0;
      chk("mem_addr latched", mem_addr, addr);
      if (ready_at == 0) begin
         repeat (TIMEOUT) step();
         chk("busy cycles", busy_seen, TIMEOUT);
      end else begin
         repeat (ready_at - 1) step();
         mem_ready = 1; mem_rdata = rdata;
         step();
         mem_ready = 0;
         chk("busy cycles", busy_seen, ready_at);
      end
      chk("op wb_valid", wb_valid, 1'b1);
      chk("op stall released", stall, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd_before;
      repeat (2) step();
      reset = 0;
      chk("reset wb_valid", wb_valid, 1'b0);
      chk("reset stall_cnt", stall_cnt, 0);

      // 1: plain ALU op
      alu_op(5'd8, 32'h10);
      chk("t1 wb_MemtoReg", wb_MemtoReg, 1'b0);
      step();
      chk("t1 single pulse", wb_valid, 1'b0);

      // 2: load, ready on BUSY cycle 3
      mem_op(1, 0, 5'd9, 32'h100, 32'h0, 3, 32'hDEADBEEF);
      chk("t2 wb_RD", wb_RD, 32'hDEADBEEF);
      chk("t2 wb_MemtoReg", wb_MemtoReg, 1'b1);
      chk("t2 stall_cnt", stall_cnt, 3);
      step();

      // 3: store, ready on BUSY cycle 1 (read+write flags -> store)
      mem_op(1, 1, 5'd3, 32'h20, 32'h55, 1, 32'h12345678);
      chk("t3 wb_RegWrite", wb_RegWrite, 1'b0);
      chk("t3 wb_RD held", wb_RD, 32'hDEADBEEF);
      chk("t3 mem_wdata", mem_wdata, 32'h55);
      step();

      // 4a: timeout
      mem_op(1, 0, 5'd10, 32'h200, 32'h0, 0, 32'h0);
      chk("t4 wb_RegWrite", wb_RegWrite, 1'b0);
      chk("t4 err_timeout", err_timeout, 1'b1);
      chk("t4 wb_RD held", wb_RD, 32'hDEADBEEF);
      chk("t4 stall_cnt", stall_cnt, 20);
      alu_op(5'd11, 32'h77);
      chk("t4 err sticky", err_timeout, 1'b1);

      // 4b: ready in the final allowed cycle after a fresh reset
      reset = 1; step(); reset = 0;
      mem_op(1, 0, 5'd12, 32'h300, 32'h0, TIMEOUT, 32'hCAFEF00D);
      chk("t4b wb_RD", wb_RD, 32'hCAFEF00D);
      chk("t4b wb_RegWrite", wb_RegWrite, 1'b1);
      chk("t4b err clear", err_timeout, 1'b0);
      step();
      // stall counter saturation: 16 + 16 clips to 31
      mem_op(1, 0, 5'd13, 32'h304, 32'h0, 0, 32'h0);
      chk("sat stall_cnt", stall_cnt, SMAX);

      // 5: reset on BUSY cycle 2
      step();
      in_valid = 1; in_MemRead = 1; in_MemWrite = 0; in_ALUResult = 32'h400;
      step();
      in_valid = 0;
      step();
      reset = 1;
      step();
      reset = 0;
      chk("t5 mem_req", mem_req, 1'b0);
      chk("t5 stall", stall, 1'b0);
      chk("t5 err", err_timeout, 1'b0);
      chk("t5 stall_cnt", stall_cnt, 0);
      chk("t5 mem_addr", mem_addr, 32'h0);
      mem_ready = 1; mem_rdata = 32'hBAD0BAD0;
      step();
      mem_ready = 0;
      chk("t5 late ready", wb_valid, 1'b0);
      chk("t5 wb_RD", wb_RD, 32'h0);

      // 6: back-to-back loads with interleaved ALU ops
      rd_before = 32'h0;
      mem_op(1, 0, 5'd1, 32'h500, 32'h0, 1, 32'h11111111);
      chk("t6 wb_RD a", wb_RD, 32'h11111111);
      mem_op(1, 0, 5'd2, 32'h504, 32'h0, 1, 32'h22222222);
      chk("t6 wb_RD b", wb_RD, 32'h22222222);
      chk("t6 wb_WriteReg b", wb_WriteReg, 5'd2);
      alu_op(5'd4, 32'hA);
      chk("t6 alu keeps RD", wb_RD, 32'h22222222);
      mem_op(1, 0, 5'd5, 32'h508, 32'h0, 1, 32'h33333333);
      chk("t6 wb_RD c", wb_RD, 32'h33333333);
      alu_op(5'd6, 32'hB);
      chk("t6 rd_before unused path", rd_before, wb_RD & 32'h0);
      step(); step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
